// File: rtl/rob_commit.sv
// Reorder buffer: tag allocation, CDB capture, in-order retirement.
// Drives the register-file commit bus and serves operand lookups.
module rob_commit #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int N_CDB  = 6,
  localparam int TW    = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    alloc_valid,
  input  logic [REG_AW-1:0]       alloc_rd,
  input  logic                    alloc_wb,
  output logic                    alloc_ready,
  output logic [TW-1:0]           alloc_tag,
  input  logic [N_CDB-1:0]        cdb_valid,
  input  logic [N_CDB*TW-1:0]     cdb_tag,
  input  logic [N_CDB*DATA_W-1:0] cdb_data,
  input  logic [TW-1:0]           qj_tag,
  input  logic [TW-1:0]           qk_tag,
  output logic                    qj_done,
  output logic                    qk_done,
  output logic [DATA_W-1:0]       qj_data,
  output logic [DATA_W-1:0]       qk_data,
  output logic                    commit_valid,
  output logic                    commit_wen,
  output logic [REG_AW-1:0]       commit_idx,
  output logic [DATA_W-1:0]       commit_data,
  output logic [TW-1:0]           commit_tag,
  output logic [TW:0]             count
);

  localparam logic [TW:0] FULL = (TW+1)'(DEPTH);

  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  done;
  logic [DEPTH-1:0]  wb;
  logic [REG_AW-1:0] rd   [DEPTH];
  logic [DATA_W-1:0] data [DEPTH];
  logic [TW-1:0]     head;
  logic [TW-1:0]     tail;
  logic              do_alloc;
  logic              do_retire;

  // No bypass from a same-cycle retire: full stays full this cycle.
  assign alloc_ready = count < FULL;
  assign alloc_tag   = tail;
  assign do_alloc    = alloc_valid & alloc_ready;
  assign do_retire   = busy[head] & done[head];

  // CDB ports take priority over stored data; highest port last wins.
  function automatic logic [DATA_W:0] lookup(input logic [TW-1:0] t);
    logic [DATA_W:0] r;
    r = '0;
    if (busy[t] && done[t])
      r = {1'b1, data[t]};
    for (int i = 0; i < N_CDB; i++) begin
      if (cdb_valid[i] && cdb_tag[i*TW +: TW] == t)
        r = {1'b1, cdb_data[i*DATA_W +: DATA_W]};
    end
    return r;
  endfunction

  assign {qj_done, qj_data} = lookup(qj_tag);
  assign {qk_done, qk_data} = lookup(qk_tag);

  // Control state: occupancy, pointers, entry flags and commit bus.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      busy         <= '0;
      done         <= '0;
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      commit_valid <= 1'b0;
      commit_wen   <= 1'b0;
      commit_idx   <= '0;
      commit_data  <= '0;
      commit_tag   <= '0;
    end else begin
      if (do_alloc) begin
        busy[tail] <= 1'b1;
        done[tail] <= 1'b0;
        tail       <= tail + TW'(1);
      end
      for (int i = 0; i < N_CDB; i++) begin
        if (cdb_valid[i] && busy[cdb_tag[i*TW +: TW]])
          done[cdb_tag[i*TW +: TW]] <= 1'b1;
      end
      if (do_retire) begin
        busy[head]  <= 1'b0;
        head        <= head + TW'(1);
        commit_idx  <= rd[head];
        commit_data <= data[head];
        commit_tag  <= head;
      end
      commit_valid <= do_retire;
      commit_wen   <= do_retire & wb[head];
      unique case ({do_alloc, do_retire})
        2'b10:   count <= count + (TW+1)'(1);
        2'b01:   count <= count - (TW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry payload; validity is carried by busy/done so no reset needed.
  always_ff @(posedge clk) begin
    if (!rst && !flush) begin
      if (do_alloc) begin
        rd[tail] <= alloc_rd;
        wb[tail] <= alloc_wb;
      end
      for (int i = 0; i < N_CDB; i++) begin
        if (cdb_valid[i] && busy[cdb_tag[i*TW +: TW]])
          data[cdb_tag[i*TW +: TW]] <= cdb_data[i*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: tb/tb_rob_commit.sv
// Directed bench for rob_commit.
// Expected values are hand-derived from the reorder buffer behaviour.
module tb_rob_commit;

  localparam int DEPTH  = 8;
  localparam int DATA_W = 32;
  localparam int REG_AW = 5;
  localparam int N_CDB  = 6;
  localparam int TW     = 3;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    flush;
  logic                    alloc_valid;
  logic [REG_AW-1:0]       alloc_rd;
  logic                    alloc_wb;
  logic                    alloc_ready;
  logic [TW-1:0]           alloc_tag;
  logic [N_CDB-1:0]        cdb_valid;
  logic [N_CDB*TW-1:0]     cdb_tag;
  logic [N_CDB*DATA_W-1:0] cdb_data;
  logic [TW-1:0]           qj_tag;
  logic [TW-1:0]           qk_tag;
  logic                    qj_done;
  logic                    qk_done;
  logic [DATA_W-1:0]       qj_data;
  logic [DATA_W-1:0]       qk_data;
  logic                    commit_valid;
  logic                    commit_wen;
  logic [REG_AW-1:0]       commit_idx;
  logic [DATA_W-1:0]       commit_data;
  logic [TW-1:0]           commit_tag;
  logic [TW:0]             count;

  int errs = 0;
  int total = 0;

  rob_commit #(
    .DEPTH(DEPTH), .DATA_W(DATA_W), .REG_AW(REG_AW), .N_CDB(N_CDB)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .alloc_valid(alloc_valid), .alloc_rd(alloc_rd), .alloc_wb(alloc_wb),
    .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .qj_tag(qj_tag), .qk_tag(qk_tag),
    .qj_done(qj_done), .qk_done(qk_done),
    .qj_data(qj_data), .qk_data(qk_data),
    .commit_valid(commit_valid), .commit_wen(commit_wen),
    .commit_idx(commit_idx), .commit_data(commit_data),
    .commit_tag(commit_tag), .count(count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    flush       = 1'b0;
    alloc_valid = 1'b0;
    alloc_rd    = '0;
    alloc_wb    = 1'b0;
    cdb_valid   = '0;
    cdb_tag     = '0;
    cdb_data    = '0;
  endtask

  task automatic cdb(input int p, input logic [TW-1:0] t,
                     input logic [DATA_W-1:0] d);
    cdb_valid[p]           = 1'b1;
    cdb_tag[p*TW +: TW]    = t;
    cdb_data[p*DATA_W +: DATA_W] = d;
  endtask

  task automatic alloc(input logic [REG_AW-1:0] r, input logic w,
                       input logic [TW-1:0] et);
    alloc_valid = 1'b1;
    alloc_rd    = r;
    alloc_wb    = w;
    #1;
    check("alloc_tag", 64'(alloc_tag), 64'(et));
    tick();
    idle();
  endtask

  task automatic commit_exp(input logic wen, input logic [REG_AW-1:0] idx,
                            input logic [DATA_W-1:0] d,
                            input logic [TW-1:0] t);
    check("commit_valid", 64'(commit_valid), 64'd1);
    check("commit_wen", 64'(commit_wen), 64'(wen));
    if (wen)
      check("commit_idx", 64'(commit_idx), 64'(idx));
    if (wen)
      check("commit_data", 64'(commit_data), 64'(d));
    check("commit_tag", 64'(commit_tag), 64'(t));
  endtask

  initial begin
    idle();
    qj_tag = '0;
    qk_tag = '0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("rst_count", 64'(count), 64'd0);
    check("rst_ready", 64'(alloc_ready), 64'd1);
    check("rst_tag", 64'(alloc_tag), 64'd0);
    check("rst_cv", 64'(commit_valid), 64'd0);
    check("rst_cdata", 64'(commit_data), 64'd0);

    // three allocs, in-order retire
    alloc(5'd1, 1'b1, 3'd0);
    alloc(5'd2, 1'b1, 3'd1);
    alloc(5'd0, 1'b0, 3'd2);
    check("count3", 64'(count), 64'd3);
    check("nocommit", 64'(commit_valid), 64'd0);
    cdb(0, 3'd1, 32'hBB);
    tick();
    idle();
    cdb(0, 3'd0, 32'hAA);
    tick();
    idle();
    check("noretire_yet", 64'(commit_valid), 64'd0);
    tick();
    commit_exp(1'b1, 5'd1, 32'hAA, 3'd0);
    tick();
    commit_exp(1'b1, 5'd2, 32'hBB, 3'd1);
    check("count1", 64'(count), 64'd1);
    tick();
    check("head_wait", 64'(commit_valid), 64'd0);
    cdb(3, 3'd2, 32'h22);
    tick();
    idle();
    check("head_wait2", 64'(commit_valid), 64'd0);
    tick();
    commit_exp(1'b0, 5'd0, 32'h0, 3'd2);
    check("count0", 64'(count), 64'd0);
    tick();
    check("empty_cv", 64'(commit_valid), 64'd0);

    // fill to full, reject, retire, wrap
    flush = 1'b1;
    tick();
    idle();
    for (int i = 0; i < DEPTH; i++)
      alloc(REG_AW'(i + 1), 1'b1, TW'(i));
    check("full_count", 64'(count), 64'd8);
    check("full_ready", 64'(alloc_ready), 64'd0);
    alloc_valid = 1'b1;
    alloc_rd    = 5'd9;
    cdb(0, 3'd0, 32'h100);
    tick();
    check("reject_count", 64'(count), 64'd8);
    cdb_valid = '0;
    #1;
    check("full_at_retire", 64'(alloc_ready), 64'd0);
    tick();
    commit_exp(1'b1, 5'd1, 32'h100, 3'd0);
    check("after_retire_cnt", 64'(count), 64'd7);
    check("after_retire_rdy", 64'(alloc_ready), 64'd1);
    idle();
    alloc(5'd9, 1'b1, 3'd0);
    check("refill_count", 64'(count), 64'd8);

    // CDB conflict and same-cycle bypass
    cdb(1, 3'd3, 32'h11);
    cdb(4, 3'd3, 32'h44);
    qj_tag = 3'd3;
    qk_tag = 3'd5;
    #1;
    check("byp_done", 64'(qj_done), 64'd1);
    check("byp_data", 64'(qj_data), 64'h44);
    check("byp_k_done", 64'(qk_done), 64'd0);
    check("byp_k_data", 64'(qk_data), 64'd0);
    tick();
    idle();
    #1;
    check("stored_done", 64'(qj_done), 64'd1);
    check("stored_data", 64'(qj_data), 64'h44);

    // flush while head is retiring
    flush = 1'b1;
    tick();
    idle();
    for (int i = 0; i < 5; i++)
      alloc(REG_AW'(10 + i), 1'b1, TW'(i));
    cdb(0, 3'd0, 32'hA0);
    cdb(2, 3'd1, 32'hA1);
    tick();
    idle();
    flush = 1'b1;
    tick();
    idle();
    check("fl_cv", 64'(commit_valid), 64'd0);
    check("fl_count", 64'(count), 64'd0);
    check("fl_tag", 64'(alloc_tag), 64'd0);
    cdb(5, 3'd2, 32'hDEAD);
    tick();
    idle();
    qj_tag = 3'd2;
    #1;
    check("late_wb_ignored", 64'(qj_done), 64'd0);
    tick();
    check("fl_no_commit", 64'(commit_valid), 64'd0);

    // simultaneous alloc + retire at count=4
    for (int i = 0; i < 4; i++)
      alloc(REG_AW'(20 + i), 1'b1, TW'(i));
    cdb(0, 3'd0, 32'h55);
    tick();
    idle();
    cdb(1, 3'd4, 32'h99);
    alloc(5'd30, 1'b1, 3'd4);
    check("sim_count", 64'(count), 64'd4);
    commit_exp(1'b1, 5'd20, 32'h55, 3'd0);
    check("sim_tail", 64'(alloc_tag), 64'd5);
    qj_tag = 3'd4;
    #1;
    check("alloc_wb_ignored", 64'(qj_done), 64'd0);
    cdb(2, 3'd1, 32'h66);
    tick();
    idle();
    tick();
    commit_exp(1'b1, 5'd21, 32'h66, 3'd1);
    check("sim_count2", 64'(count), 64'd3);

    // reset mid-stream
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst2_count", 64'(count), 64'd0);
    check("rst2_cv", 64'(commit_valid), 64'd0);
    check("rst2_tag", 64'(alloc_tag), 64'd0);

    $display("Result: errors=%0d of %0d checks", errs, total);
    $finish;
  end

endmodule

// File: doc/rob_commit.md
# rob_commit

Reorder buffer holding in-flight instructions between issue and register-file writeback. Allocates one tag per issued instruction and captures results broadcast on the common data bus (CDB). Retires entries strictly in program order and drives the commit bus (`commit_wen`/`commit_idx`/`commit_data`) into the register file. Also serves operand lookups from the order manager, with same-cycle CDB bypass.

## Interface

- `DEPTH`, 8: number of entries; power of two; tag width `TW = log2(DEPTH)`.
- `DATA_W`, 32: result width.
- `REG_AW`, 5: architectural register index width.
- `N_CDB`, 6: CDB source ports (ADD1..3, MUL1..2, LS).
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `flush`  in  1  synchronous clear of all entries.
- `alloc_valid`  in  1  issue requests an entry.
- `alloc_rd`  in  REG_AW  destination register.
- `alloc_wb`  in  1  instruction writes a register (0 for stores and branches).
- `alloc_ready`  out  1  combinational; `count < DEPTH`.
- `alloc_tag`  out  TW  combinational; equals the tail pointer (tag granted on accept).
- `cdb_valid`  in  N_CDB  per-port result valid.
- `cdb_tag`  in  N_CDB*TW  packed tags; port i at `[i*TW +: TW]`.
- `cdb_data`  in  N_CDB*DATA_W  packed results.
- `qj_tag`, `qk_tag`  in  TW  operand lookup tags.
- `qj_done`, `qk_done`  out  1  combinational; result available.
- `qj_data`, `qk_data`  out  DATA_W  combinational; result value.
- `commit_valid`  out  1  registered; an entry retired.
- `commit_wen`  out  1  registered; register-file write enable.
- `commit_idx`  out  REG_AW  registered.
- `commit_data`  out  DATA_W  registered.
- `commit_tag`  out  TW  registered; retired tag, used to clear the rename table.
- `count`  out  TW+1  registered occupancy.

## Operation

- Per-entry state: `busy`, `done`, `wb`, `rd`, `data`. Pointers `head` and `tail` are TW bits and wrap modulo DEPTH.
- **Allocate:** on `alloc_valid & alloc_ready`, set `entry[tail]` to busy=1, done=0, `rd`/`wb` from the inputs. `tail++`.
- **Writeback:** for each port i with `cdb_valid[i]`, if `entry[tag].busy` is set, write done=1 and `data`.
  - A writeback to a non-busy entry is ignored.
  - If several ports carry the same tag in one cycle, the highest port index wins.
- **Retire:** when `entry[head].busy & entry[head].done` (registered state), clear busy and `head++`. At the same edge, load the commit outputs:
  - `commit_valid` = 1, `commit_wen` = `wb`, `commit_idx` = `rd`, `commit_data` = `data`, `commit_tag` = `head`.
  - Otherwise load `commit_valid` = `commit_wen` = 0; idx, data and tag hold their values.
- At most one retirement per cycle.
- **Count:** +1 on allocate only, -1 on retire only, unchanged when both happen.
- **Lookup:** `qX_done` = 1 when either of these holds:
  - any `cdb_valid[i]` with `cdb_tag[i] == qX_tag` (data taken from that port, highest index wins);
  - else `entry[qX_tag].busy & done` (data taken from the entry).
  - Otherwise `qX_done` = 0 and `qX_data` = 0.
- **Flush:** clears every busy bit, `head` = `tail` = `count` = 0, and commit outputs to 0 at the next edge. Flush overrides allocate, writeback and retire in the same cycle.
- **Reset:** same effect as flush. All registered outputs are 0. After reset `alloc_ready` = 1 and `alloc_tag` = 0.

## Timing

- CDB result in cycle n sets `done` at the end of n. If the entry is at head, it retires at the end of n+1 and `commit_wen` is high during n+2. CDB-to-commit latency is 2 cycles.
- Allocate in cycle n: the entry is visible to writeback from cycle n+1. A writeback to that tag in cycle n is ignored.
- **Full (`count` == DEPTH):** `alloc_ready` = 0, even if a retire happens that same cycle (no bypass). Allocation resumes the following cycle.
- **Empty:** no retire. `commit_valid` = 0.
- Back-to-back done entries retire one per cycle with `commit_valid` held high.
- Pointer wrap: after tag DEPTH-1, the next allocation gets tag 0.
- A flush or rst asserted mid-stream takes effect at that edge. No partial commits follow.

## Test plan

- **Reset, then 3 allocs:** (rd=1,wb=1), (rd=2,wb=1), (rd=0,wb=0) -> tags 0,1,2; `count`=3; no commit.
- **In-order retire:** CDB tag1=0xBB in cycle 10, tag0=0xAA in cycle 11 -> commit (idx1? no) idx0… required order: `commit_wen` in cycle 13 with idx=1, data=0xAA; cycle 14 with idx=2, data=0xBB; tag2 done -> `commit_valid`=1, `commit_wen`=0.
- **Full:** 8 allocs without writeback -> `alloc_ready`=0, `count`=8. A ninth `alloc_valid` is rejected. Writeback tag0 -> one retire, then `alloc_ready`=1 and the next alloc gets tag 0 (wrap).
- **CDB conflict and bypass:** ports 1 and 4 carry tag3 with 0x11 and 0x44 -> `qj_tag`=3 gives done=1, data 0x44 in the same cycle; the entry stores 0x44.
- **Flush mid-stream:** 5 entries, 2 done; assert flush while head is retiring -> next cycle `commit_valid`=0, `count`=0, `alloc_tag`=0; a late CDB writeback to tag 2 is ignored.
- **Simultaneous alloc + retire at count=4** -> `count` stays 4, `tail` and `head` both advance.
